pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch stage of the RISC-V core, one step upstream of the decoder and ALU. It holds the PC, issues single-outstanding requests to instruction memory, and hands each fetched word to the decoder over a valid/ready handshake. It consumes the ALU `Flag` and the execute-stage control to redirect the PC on taken branches and on JAL/JALR.

---
 rtl/pc_fetch_unit.sv | 78 +++++++
 tb/tb_pc_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and single-outstanding instruction fetch with branch/jump redirect
// Ports:
//   clk, rst_n                                       clock, async active-low reset
//   instr_req_o, instr_addr_o, instr_gnt_i           fetch request / address / grant
//   instr_rvalid_i, instr_rdata_i                    fetch response
//   instr_valid_o, instr_o, instr_pc_o, instr_ready_i  decoder handshake
//   ex_valid_i, branch_i, jal_i, jalr_i, Flag        execute-stage control
//   ex_pc_i, imm_i, rs1_i                            redirect operands
//   link_o, misaligned_o                             JAL/JALR link value, misaligned-target pulse
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        ex_valid_i,
  input  logic        branch_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic        Flag,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  output logic [31:0] link_o,
  output logic        misaligned_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
  state_t state, state_nx;
  logic take, redirect;
  logic [31:0] target, pc;
  assign take = ex_valid_i & (jal_i | jalr_i | (branch_i & Flag));
  assign target = jalr_i ? ((rs1_i + imm_i) & 32'hFFFF_FFFE) : ex_pc_i + imm_i;
  // a target with bit 1 set is rejected: PC holds, only the error pulse fires
  assign redirect = take & ~target[1];
  assign link_o = ex_pc_i + 32'd4;
  assign instr_addr_o = pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // an accepted request whose target is now wrong must drain through DROP
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = REQ;
      REQ:  state_nx = instr_gnt_i ? (redirect ? DROP : WAIT) : REQ;
      WAIT: state_nx = instr_rvalid_i ? (redirect ? REQ : HOLD) : (redirect ? DROP : WAIT);
      HOLD: state_nx = (redirect | instr_ready_i) ? REQ : HOLD;
      DROP: state_nx = instr_rvalid_i ? REQ : DROP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    instr_req_o = state == REQ;
    instr_valid_o = state == HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      instr_o <= 32'h0000_0013;
      instr_pc_o <= 32'h0;
      misaligned_o <= 1'b0;
    end else begin
      pc <= redirect ? target : (state == HOLD && instr_ready_i) ? pc + 32'd4 : pc;
      misaligned_o <= take & target[1];
      if (state == WAIT && instr_rvalid_i && !redirect) begin
        instr_o <= instr_rdata_i;
        instr_pc_o <= pc;
      end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed bench with a transaction-level fetch model and per-cycle compare
module tb_pc_fetch_unit;
  logic clk = 0, rst_n = 0;
  logic instr_req_o, instr_valid_o, misaligned_o;
  logic [31:0] instr_addr_o, instr_o, instr_pc_o, link_o;
  logic instr_gnt_i = 0, instr_rvalid_i = 0, instr_ready_i = 0;
  logic [31:0] instr_rdata_i = 0;
  logic ex_valid_i = 0, branch_i = 0, jal_i = 0, jalr_i = 0, flag = 0;
  logic [31:0] ex_pc_i = 0, imm_i = 0, rs1_i = 0;
  int n_vec = 0, n_err = 0;
  bit auto_gnt = 1;
  int rv_lat = 1;
  logic [31:0] acc_q[$];

  pc_fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .ex_valid_i(ex_valid_i), .branch_i(branch_i),
    .jal_i(jal_i), .jalr_i(jalr_i), .Flag(flag), .ex_pc_i(ex_pc_i), .imm_i(imm_i),
    .rs1_i(rs1_i), .link_o(link_o), .misaligned_o(misaligned_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks whether a request is wanted, whether a response is
  // owed (live or stale), and whether an instruction is being offered.
  logic [31:0] m_pc, m_instr, m_ipc;
  bit m_req, m_have, m_mis, m_boot;
  int m_out;

  task automatic m_reset();
    m_pc = 32'h100; m_instr = 32'h13; m_ipc = 0;
    m_req = 0; m_have = 0; m_mis = 0; m_boot = 1; m_out = 0;
  endtask

  task automatic m_step();
    logic take, acc, arr, hs;
    logic [31:0] tgt;
    take = ex_valid_i & (jal_i | jalr_i | (branch_i & flag));
    tgt = jalr_i ? ((rs1_i + imm_i) & 32'hFFFF_FFFE) : ex_pc_i + imm_i;
    acc = m_req & instr_gnt_i;
    arr = (m_out != 0) & instr_rvalid_i;
    hs = m_have & instr_ready_i;
    m_mis = take & tgt[1];
    if (take && !tgt[1]) begin
      m_pc = tgt;
      m_have = 0;
      m_out = (acc || (m_out != 0 && !arr)) ? 2 : 0;
      m_req = m_out == 0;
    end else begin
      if (m_boot) m_req = 1;
      if (acc) begin
        m_out = 1; m_req = 0;
      end else if (arr) begin
        if (m_out == 1) begin
          m_instr = instr_rdata_i; m_ipc = m_pc; m_have = 1;
        end else m_req = 1;
        m_out = 0;
      end
      if (hs) begin
        m_pc = m_pc + 4; m_have = 0; m_req = 1;
      end
    end
    m_boot = 0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("req", instr_req_o, m_req);
    chk("addr", instr_addr_o, m_pc);
    chk("valid", instr_valid_o, m_have);
    chk("instr", instr_o, m_instr);
    chk("instr_pc", instr_pc_o, m_ipc);
    chk("misaligned", misaligned_o, m_mis);
    chk("link", link_o, ex_pc_i + 32'd4);
  end

  // Instruction memory: grants while auto_gnt, answers rv_lat cycles after grant with addr ^ DEAD0000.
  initial begin
    bit g, rv, pend;
    int cnt;
    logic [31:0] a, paddr;
    pend = 0; cnt = 0; paddr = 0;
    forever begin
      @(posedge clk);
      g = instr_req_o & instr_gnt_i;
      a = instr_addr_o;
      rv = instr_rvalid_i;
      #2;
      if (rv) pend = 0;
      if (g) begin
        pend = 1; cnt = rv_lat; paddr = a; acc_q.push_back(a);
      end
      if (pend && cnt <= 1) begin
        instr_rvalid_i = 1; instr_rdata_i = paddr ^ 32'hDEAD_0000;
      end else begin
        instr_rvalid_i = 0;
        if (pend) cnt--;
      end
      instr_gnt_i = auto_gnt & instr_req_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!instr_valid_o && n < 60) begin tick(); n++; end
    if (!instr_valid_o) begin
      n_vec++; n_err++;
      $display("FAIL wait_valid: got timeout expected instr_valid_o at %0t", $time);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!instr_req_o && n < 60) begin tick(); n++; end
    if (!instr_req_o) begin
      n_vec++; n_err++;
      $display("FAIL wait_req: got timeout expected instr_req_o at %0t", $time);
    end
  endtask

  task automatic clear_ex();
    ex_valid_i = 0; branch_i = 0; jal_i = 0; jalr_i = 0; flag = 0;
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: got no finish expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    instr_ready_i = 1;
    repeat (3) tick();
    #1 chk("rst_req", instr_req_o, 0);
    chk("rst_instr", instr_o, 32'h13);
    chk("rst_addr", instr_addr_o, 32'h100);
    rst_n = 1;
    // sequential fetch
    wait_valid();
    chk("t1_instr", instr_o, 32'hDEAD_0100);
    chk("t1_ipc", instr_pc_o, 32'h100);
    for (int i = 0; i < 60 && acc_q.size() < 3; i++) tick();
    chk("t1_a0", acc_q.size() > 0 ? acc_q[0] : 32'hX, 32'h100);
    chk("t1_a1", acc_q.size() > 1 ? acc_q[1] : 32'hX, 32'h104);
    chk("t1_a2", acc_q.size() > 2 ? acc_q[2] : 32'hX, 32'h108);
    instr_ready_i = 0;
    wait_valid();
    chk("t1_ipc3", instr_pc_o, 32'h108);
    // taken branch in HOLD, same-cycle ready must be ignored
    ex_valid_i = 1; branch_i = 1; flag = 1; ex_pc_i = 32'h200; imm_i = 32'hFFFF_FFF8;
    instr_ready_i = 1;
    tick();
    clear_ex(); instr_ready_i = 0;
    chk("t2_addr", instr_addr_o, 32'h1F8);
    chk("t2_valid", instr_valid_o, 0);
    chk("t2_req", instr_req_o, 1);
    wait_valid();
    chk("t2_ipc", instr_pc_o, 32'h1F8);
    chk("t2_instr", instr_o, 32'hDEAD_01F8);
    // not-taken branch: sequential advance
    ex_valid_i = 1; branch_i = 1; flag = 0; ex_pc_i = 32'h200; imm_i = 32'hFFFF_FFF8;
    instr_ready_i = 1;
    tick();
    clear_ex(); instr_ready_i = 0;
    chk("t3_addr", instr_addr_o, 32'h1FC);
    chk("t3_req", instr_req_o, 1);
    // JALR with odd sum while the current request is granted
    rv_lat = 3;
    ex_valid_i = 1; jalr_i = 1; rs1_i = 32'h301; imm_i = 32'h10; ex_pc_i = 32'h500;
    #1 chk("t4_link", link_o, 32'h504);
    tick();
    clear_ex();
    chk("t4_req_drop", instr_req_o, 0);
    chk("t4_addr", instr_addr_o, 32'h310);
    wait_req();
    chk("t4_req_addr", instr_addr_o, 32'h310);
    wait_valid();
    chk("t4_ipc", instr_pc_o, 32'h310);
    chk("t4_instr", instr_o, 32'hDEAD_0310);
    // misaligned JAL: one-cycle pulse, PC unchanged
    ex_valid_i = 1; jal_i = 1; ex_pc_i = 32'h40; imm_i = 32'h6;
    #1 chk("t5_link", link_o, 32'h44);
    tick();
    clear_ex();
    chk("t5_mis", misaligned_o, 1);
    chk("t5_addr", instr_addr_o, 32'h310);
    chk("t5_valid", instr_valid_o, 1);
    tick();
    chk("t5_mis_off", misaligned_o, 0);
    chk("t5_addr2", instr_addr_o, 32'h310);
    // reset while waiting for data; the late response must be ignored
    instr_ready_i = 1;
    tick();
    chk("t6_req", instr_req_o, 1);
    tick();
    rst_n = 0;
    #1 chk("t6_rst_req", instr_req_o, 0);
    chk("t6_rst_valid", instr_valid_o, 0);
    chk("t6_rst_instr", instr_o, 32'h13);
    chk("t6_rst_ipc", instr_pc_o, 32'h0);
    chk("t6_rst_addr", instr_addr_o, 32'h100);
    tick();
    rst_n = 1;
    tick();
    chk("t6_stale_rv", instr_rvalid_i, 1);
    chk("t6_instr_a", instr_o, 32'h13);
    tick();
    chk("t6_instr_b", instr_o, 32'h13);
    wait_valid();
    chk("t6_instr", instr_o, 32'hDEAD_0100);
    chk("t6_ipc", instr_pc_o, 32'h100);
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
